// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter.
// Captures a WIDTH-bit pattern and a repeat count over a valid/ready handshake,
// then sends the pattern MSB-first, one bit per clock, with GAP idle cycles
// between repetitions.
//
// Optional feature macro: SEQ_PATTERN_TX_PARITY_EN
//   When defined, each frame is followed by one even-parity bit (XOR of the
//   captured pattern) with out_valid=1.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-high reset
//   load_valid    load request
//   load_ready    load accepted when high (idle only)
//   load_pattern  pattern to send, MSB first
//   load_count    number of frames, 0 treated as 1
//   out           registered serial data bit
//   out_valid     out carries a pattern (or parity) bit
//   busy          high from acceptance until the last bit has been sent
//   done          one-cycle pulse after the final bit of the final frame
module seq_pattern_tx #(
   parameter int unsigned      WIDTH           = 5,
   parameter logic [WIDTH-1:0] DEFAULT_PATTERN = 5'b10110,
   parameter int unsigned      GAP             = 1,
   parameter int unsigned      CNT_W           = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_pattern,
   input  logic [CNT_W-1:0] load_count,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BIT_W = $clog2(WIDTH + 1);
   localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StShift  = 2'd1,
`ifdef SEQ_PATTERN_TX_PARITY_EN
      StGap    = 2'd2,
      StParity = 2'd3
`else
      StGap    = 2'd2
`endif
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] shreg_q;  // bits still to send in the current frame, MSB next
   logic [WIDTH-1:0] pat_q;    // captured pattern, reloaded for each repetition
   logic [CNT_W-1:0] cnt_q;    // captured frame count (at least 1)
   logic [CNT_W-1:0] rep_q;    // frames started so far, saturates at cnt_q
   logic [BIT_W-1:0] bit_q;    // bits of the current frame already presented
   logic [GAP_W-1:0] gap_q;    // gap cycle currently presented

   logic eof;      // the last bit of a frame is on out this cycle
   logic more;     // further repetitions remain
   logic restart;  // next edge starts a new frame at the MSB

`ifdef SEQ_PATTERN_TX_PARITY_EN
   assign eof = (state_q == StParity);
`else
   assign eof = (state_q == StShift) && (bit_q == BIT_W'(WIDTH));
`endif
   assign more    = (rep_q < cnt_q);
   assign restart = (eof && more && (GAP == 0)) ||
                    ((state_q == StGap) && (gap_q == GAP_W'(GAP)));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         shreg_q    <= DEFAULT_PATTERN;
         pat_q      <= DEFAULT_PATTERN;
         cnt_q      <= '0;
         rep_q      <= '0;
         bit_q      <= '0;
         gap_q      <= '0;
         out        <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (load_valid) begin
                  state_q    <= StShift;
                  pat_q      <= load_pattern;
                  shreg_q    <= load_pattern << 1;
                  cnt_q      <= (load_count == '0) ? CNT_W'(1) : load_count;
                  rep_q      <= CNT_W'(1);
                  bit_q      <= BIT_W'(1);
                  gap_q      <= '0;
                  out        <= load_pattern[WIDTH-1];
                  out_valid  <= 1'b1;
                  busy       <= 1'b1;
                  load_ready <= 1'b0;
               end
            end
            default: begin
               if (restart) begin
                  state_q   <= StShift;
                  shreg_q   <= pat_q << 1;
                  bit_q     <= BIT_W'(1);
                  rep_q     <= rep_q + CNT_W'(1);
                  out       <= pat_q[WIDTH-1];
                  out_valid <= 1'b1;
               end else if (eof && more) begin
                  state_q   <= StGap;
                  gap_q     <= GAP_W'(1);
                  out       <= 1'b0;
                  out_valid <= 1'b0;
               end else if (eof) begin
                  state_q    <= StIdle;
                  out        <= 1'b0;
                  out_valid  <= 1'b0;
                  busy       <= 1'b0;
                  load_ready <= 1'b1;
                  done       <= 1'b1;
               end else if (state_q == StGap) begin
                  gap_q <= gap_q + GAP_W'(1);
               end else if (state_q == StShift) begin
                  if (bit_q != BIT_W'(WIDTH)) begin
                     out     <= shreg_q[WIDTH-1];
                     shreg_q <= shreg_q << 1;
                     bit_q   <= bit_q + BIT_W'(1);
                  end
`ifdef SEQ_PATTERN_TX_PARITY_EN
                  else begin
                     // even parity: XOR of all captured pattern bits
                     state_q <= StParity;
                     out     <= ^pat_q;
                  end
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

`ifdef SEQ_PATTERN_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clock;
   logic       reset;
   logic       a_lv, b_lv;
   logic [4:0] load_pattern;
   logic [3:0] load_count;
   logic       a_rdy, a_out, a_ov, a_busy, a_done;
   logic       b_rdy, b_out, b_ov, b_busy, b_done;
   logic       sel;
   logic [4:0] obs;

   int nchk = 0;
   int nerr = 0;

   // DUT a: GAP=1, DUT b: GAP=0 (back-to-back frames)
   seq_pattern_tx #(.WIDTH(5), .DEFAULT_PATTERN(5'b10110), .GAP(1), .CNT_W(4)) dut_a (
      .clock(clock), .reset(reset), .load_valid(a_lv), .load_ready(a_rdy),
      .load_pattern(load_pattern), .load_count(load_count),
      .out(a_out), .out_valid(a_ov), .busy(a_busy), .done(a_done));

   seq_pattern_tx #(.WIDTH(5), .DEFAULT_PATTERN(5'b10110), .GAP(0), .CNT_W(4)) dut_b (
      .clock(clock), .reset(reset), .load_valid(b_lv), .load_ready(b_rdy),
      .load_pattern(load_pattern), .load_count(load_count),
      .out(b_out), .out_valid(b_ov), .busy(b_busy), .done(b_done));

   // observed vector: {out, out_valid, busy, done, load_ready}
   assign obs = sel ? {b_out, b_ov, b_busy, b_done, b_rdy}
                    : {a_out, a_ov, a_busy, a_done, a_rdy};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic       lv;
      logic [4:0] pat;
      logic [3:0] cnt;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic lv, input logic [4:0] pat,
                      input logic [3:0] cnt, input logic [4:0] exp);
      vec_t v;
      v.rst = rst; v.lv = lv; v.pat = pat; v.cnt = cnt; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got {out,ov,busy,done,rdy}=%b expected %b", name, got, exp);
      end
   endtask

   // Load a pattern on one DUT, then check every cycle until the done cycle.
   task automatic run_xfer(input bit use_b, input logic [4:0] pat, input logic [3:0] cnt,
                           input int gap, input int abort_at, input int inject_at,
                           input string tag);
      logic [1:0] exp_q[$];
      int n;
      n = (cnt == 0) ? 1 : int'(cnt);
      for (int f = 0; f < n; f++) begin
         for (int k = 4; k >= 0; k--) exp_q.push_back({pat[k], 1'b1});
         if (PAR == 1) exp_q.push_back({^pat, 1'b1});
         if (f < n - 1) for (int g = 0; g < gap; g++) exp_q.push_back(2'b00);
      end
      sel = use_b;
      load_pattern = pat;
      load_count   = cnt;
      if (use_b) b_lv = 1'b1; else a_lv = 1'b1;
      @(posedge clock); #1;
      a_lv = 1'b0; b_lv = 1'b0;
      load_pattern = 5'b0; load_count = 4'd0;
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("%s cyc%0d", tag, i + 1), obs, {exp_q[i], 3'b100});
         if (i == abort_at) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            chk($sformatf("%s abort", tag), obs, 5'b00001);
            @(posedge clock); #1;
            chk($sformatf("%s no done after abort", tag), obs, 5'b00001);
            return;
         end
         if (i == inject_at) begin
            load_pattern = 5'b01001;
            load_count   = 4'd1;
            if (use_b) b_lv = 1'b1; else a_lv = 1'b1;
         end
         @(posedge clock); #1;
         a_lv = 1'b0; b_lv = 1'b0;
      end
      chk($sformatf("%s done", tag), obs, 5'b00011);
      @(posedge clock); #1;
      chk($sformatf("%s idle", tag), obs, 5'b00001);
   endtask

   initial begin
      reset = 1'b1; a_lv = 1'b0; b_lv = 1'b0; sel = 1'b0;
      load_pattern = 5'b0; load_count = 4'd0;

      // reset, then 10110 count 1 on DUT a
      add(1'b1, 1'b0, 5'b00000, 4'd0, 5'b00001);
      add(1'b0, 1'b1, 5'b10110, 4'd1, 5'b11100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b01100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b11100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b11100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b01100);
      if (PAR == 1) add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b11100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b00011);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b00001);
      // count 0 acts as 1; load_valid while busy is ignored and not queued
      add(1'b0, 1'b1, 5'b10110, 4'd0, 5'b11100);
      add(1'b0, 1'b1, 5'b01001, 4'd1, 5'b01100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b11100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b11100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b01100);
      if (PAR == 1) add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b11100);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b00011);
      add(1'b0, 1'b0, 5'b00000, 4'd0, 5'b00001);

      for (int i = 0; i < tbl.size(); i++) begin
         reset        = tbl[i].rst;
         a_lv         = tbl[i].lv;
         load_pattern = tbl[i].pat;
         load_count   = tbl[i].cnt;
         @(posedge clock); #1;
         chk($sformatf("tbl%0d", i), obs, tbl[i].exp);
      end
      reset = 1'b0; a_lv = 1'b0;

      run_xfer(1'b0, 5'b10110, 4'd3, 1, -1, -1, "rep3");
      run_xfer(1'b1, 5'b10110, 4'd2, 0, -1, 2, "b2b");
      run_xfer(1'b0, 5'b11100, 4'd4, 1, (5 + PAR + 1) + 3, -1, "abort");
      run_xfer(1'b0, 5'b10110, 4'd1, 1, -1, -1, "post_abort");
      run_xfer(1'b0, 5'b10110, 4'd0, 1, -1, -1, "cnt0");
      run_xfer(1'b0, 5'b10010, 4'd1, 1, -1, -1, "p10010");
      run_xfer(1'b0, 5'b10110, 4'd2, 1, -1, -1, "rep2");
      run_xfer(1'b0, 5'b10101, 4'd15, 1, -1, -1, "max15");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
